// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the frame-buffer read scheduler.
package fb_sched_pkg;

    localparam int unsigned FB_BUF_CNT_DEFAULT = 3;
    localparam int unsigned FB_BUF_IDX_WIDTH   = 2;

    typedef logic [FB_BUF_IDX_WIDTH-1:0] buf_idx_t;

    typedef enum logic [1:0] {
        IDLE_S,
        FRAME_START_S,
        ISSUE_S,
        WAIT_LINE_S
    } sched_state_t;

endpackage

// File: rtl/fb_buf_tracker.sv
// Tracks the newest completely written buffer and holds the index locked for readout.
module fb_buf_tracker
    import fb_sched_pkg::*;
#(
    parameter int unsigned BUF_CNT       = FB_BUF_CNT_DEFAULT,
    parameter int unsigned BUF_IDX_WIDTH = FB_BUF_IDX_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_done_i,
    input  logic [BUF_IDX_WIDTH-1:0] wr_buf_i,
    input  logic                     capture_i,
    input  logic                     lock_set_i,
    input  logic                     lock_clr_i,
    output logic [BUF_IDX_WIDTH-1:0] sel_buf_o,
    output logic                     sel_vld_o,
    output logic [BUF_IDX_WIDTH-1:0] lock_buf_o,
    output logic                     lock_vld_o
);

    logic [BUF_IDX_WIDTH-1:0] latest_buf_q;
    logic                     latest_vld_q;
    logic                     wr_ok;

    assign wr_ok = wr_done_i && (int'(wr_buf_i) < int'(BUF_CNT));

    // A completion in the same cycle as the request wins over the stored index.
    assign sel_buf_o = wr_ok ? wr_buf_i : latest_buf_q;
    assign sel_vld_o = wr_ok | latest_vld_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            latest_buf_q <= '0;
            latest_vld_q <= 1'b0;
            lock_buf_o   <= '0;
            lock_vld_o   <= 1'b0;
        end else begin
            if (wr_ok) begin
                latest_buf_q <= wr_buf_i;
                latest_vld_q <= 1'b1;
            end
            if (capture_i) begin
                lock_buf_o <= sel_buf_o;
            end
            if (lock_set_i) begin
                lock_vld_o <= 1'b1;
            end else if (lock_clr_i) begin
                lock_vld_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fb_rd_frame_scheduler.sv
// Per-frame buffer selection and per-line read strobe sequencing for the line reader.
// Optional watchdog on line completion: define FB_RD_SCHED_WATCHDOG_EN.
module fb_rd_frame_scheduler
    import fb_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned MAX_PKT_SIZE_B     = 2048,
    parameter int unsigned MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B),
    parameter int unsigned LINES_WIDTH        = 12,
    parameter int unsigned BUF_CNT            = FB_BUF_CNT_DEFAULT,
    parameter int unsigned BUF_IDX_WIDTH      = FB_BUF_IDX_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [ADDR_WIDTH-1:0]         buf_stride_i,
    input  logic [ADDR_WIDTH-1:0]         line_stride_i,
    input  logic [MAX_PKT_SIZE_WIDTH-1:0] line_size_i,
    input  logic [LINES_WIDTH-1:0]        frame_lines_i,
    input  logic                          frame_req_i,
    input  logic                          wr_done_i,
    input  logic [BUF_IDX_WIDTH-1:0]      wr_buf_i,
    input  logic                          line_done_i,
    output logic                          rd_stb_o,
    output logic [ADDR_WIDTH-1:0]         rd_addr_o,
    output logic [MAX_PKT_SIZE_WIDTH-1:0] rd_size_o,
    output logic [BUF_IDX_WIDTH-1:0]      rd_buf_o,
    output logic                          rd_buf_vld_o,
    output logic                          frame_done_o,
    output logic                          frame_skip_o,
    output logic                          frame_overrun_o,
    output logic                          timeout_o
);

    sched_state_t                  state_q;
    logic [ADDR_WIDTH-1:0]         base_q;
    logic [ADDR_WIDTH-1:0]         buf_stride_q;
    logic [ADDR_WIDTH-1:0]         line_stride_q;
    logic [MAX_PKT_SIZE_WIDTH-1:0] size_q;
    logic [LINES_WIDTH-1:0]        lines_q;
    logic [LINES_WIDTH-1:0]        line_cnt_q;
    logic [ADDR_WIDTH-1:0]         buf_base;
    logic [BUF_IDX_WIDTH-1:0]      sel_buf;
    logic                          sel_vld;
    logic                          accept;
    logic                          last_line;
    logic                          wd_fire;

    assign accept = (state_q == IDLE_S) && frame_req_i && sel_vld &&
                    (frame_lines_i != '0) && (line_size_i != '0);

    assign last_line = (state_q == WAIT_LINE_S) && line_done_i &&
                       (line_cnt_q == LINES_WIDTH'(1));

    fb_buf_tracker #(
        .BUF_CNT       (BUF_CNT),
        .BUF_IDX_WIDTH (BUF_IDX_WIDTH)
    ) u_buf_tracker (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_done_i  (wr_done_i),
        .wr_buf_i   (wr_buf_i),
        .capture_i  (accept),
        .lock_set_i (state_q == FRAME_START_S),
        .lock_clr_i (last_line | wd_fire),
        .sel_buf_o  (sel_buf),
        .sel_vld_o  (sel_vld),
        .lock_buf_o (rd_buf_o),
        .lock_vld_o (rd_buf_vld_o)
    );

    // Buffer base = base + idx * stride, one shifted stride per set index bit.
    always_comb begin
        buf_base = base_q;
        for (int unsigned b = 0; b < BUF_IDX_WIDTH; b++) begin
            if (rd_buf_o[b]) begin
                buf_base = buf_base + (buf_stride_q << b);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE_S;
            base_q          <= '0;
            buf_stride_q    <= '0;
            line_stride_q   <= '0;
            size_q          <= '0;
            lines_q         <= '0;
            line_cnt_q      <= '0;
            rd_stb_o        <= 1'b0;
            rd_addr_o       <= '0;
            rd_size_o       <= '0;
            frame_done_o    <= 1'b0;
            frame_skip_o    <= 1'b0;
            frame_overrun_o <= 1'b0;
        end else begin
            rd_stb_o        <= 1'b0;
            frame_done_o    <= 1'b0;
            frame_skip_o    <= 1'b0;
            frame_overrun_o <= frame_req_i && (state_q != IDLE_S);
            case (state_q)
                IDLE_S: begin
                    if (accept) begin
                        base_q        <= base_addr_i;
                        buf_stride_q  <= buf_stride_i;
                        line_stride_q <= line_stride_i;
                        size_q        <= line_size_i;
                        lines_q       <= frame_lines_i;
                        state_q       <= FRAME_START_S;
                    end else if (frame_req_i) begin
                        frame_skip_o <= 1'b1;
                    end
                end
                FRAME_START_S: begin
                    rd_addr_o  <= buf_base;
                    rd_size_o  <= size_q;
                    line_cnt_q <= lines_q;
                    rd_stb_o   <= 1'b1;
                    state_q    <= ISSUE_S;
                end
                ISSUE_S: begin
                    // First line strobes while in ISSUE_S; later lines strobe on its exit,
                    // giving N+2 latency from the request and M+2 from each line_done.
                    rd_stb_o <= ~rd_stb_o;
                    state_q  <= WAIT_LINE_S;
                end
                WAIT_LINE_S: begin
                    if (line_done_i) begin
                        rd_addr_o  <= rd_addr_o + line_stride_q;
                        line_cnt_q <= line_cnt_q - LINES_WIDTH'(1);
                        if (last_line) begin
                            frame_done_o <= 1'b1;
                            state_q      <= IDLE_S;
                        end else begin
                            state_q <= ISSUE_S;
                        end
                    end else if (wd_fire) begin
                        state_q <= IDLE_S;
                    end
                end
                default: state_q <= IDLE_S;
            endcase
        end
    end

`ifdef FB_RD_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;

    // Counter holds cycles elapsed since the current line's strobe.
    assign wd_fire = (state_q == WAIT_LINE_S) && !line_done_i && !rd_stb_o &&
                     (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wd_cnt_q  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= wd_fire;
            if (rd_stb_o) begin
                wd_cnt_q <= WD_W'(1);
            end else if ((state_q == WAIT_LINE_S) && !line_done_i && !wd_fire) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end else begin
                wd_cnt_q <= '0;
            end
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fb_rd_frame_scheduler.sv
// Randomized self-checking bench for fb_rd_frame_scheduler against a frame-level reference model.
module tb_fb_rd_frame_scheduler;
    import fb_sched_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned SW = 11;
    localparam int unsigned LW = 12;
    localparam int unsigned BW = 2;
    localparam int unsigned BC = 3;
    localparam int unsigned TO = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] base_addr, buf_stride, line_stride;
    logic [SW-1:0] line_size;
    logic [LW-1:0] frame_lines;
    logic          frame_req, wr_done, line_done;
    logic [BW-1:0] wr_buf;
    logic          rd_stb, rd_buf_vld, frame_done, frame_skip, frame_overrun, timeout;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_size;
    logic [BW-1:0] rd_buf;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: newest valid completed buffer.
    bit          mdl_vld;
    int unsigned mdl_buf;

    always #5 clk = ~clk;

    fb_rd_frame_scheduler #(
        .ADDR_WIDTH         (AW),
        .MAX_PKT_SIZE_B     (2048),
        .MAX_PKT_SIZE_WIDTH (SW),
        .LINES_WIDTH        (LW),
        .BUF_CNT            (BC),
        .BUF_IDX_WIDTH      (BW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .base_addr_i     (base_addr),
        .buf_stride_i    (buf_stride),
        .line_stride_i   (line_stride),
        .line_size_i     (line_size),
        .frame_lines_i   (frame_lines),
        .frame_req_i     (frame_req),
        .wr_done_i       (wr_done),
        .wr_buf_i        (wr_buf),
        .line_done_i     (line_done),
        .rd_stb_o        (rd_stb),
        .rd_addr_o       (rd_addr),
        .rd_size_o       (rd_size),
        .rd_buf_o        (rd_buf),
        .rd_buf_vld_o    (rd_buf_vld),
        .frame_done_o    (frame_done),
        .frame_skip_o    (frame_skip),
        .frame_overrun_o (frame_overrun),
        .timeout_o       (timeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_set(input logic [AW-1:0] b, input logic [AW-1:0] bs,
                           input logic [AW-1:0] ls, input logic [SW-1:0] sz,
                           input logic [LW-1:0] nl);
        base_addr   = b;
        buf_stride  = bs;
        line_stride = ls;
        line_size   = sz;
        frame_lines = nl;
    endtask

    task automatic cfg_random();
        base_addr   = $urandom;
        buf_stride  = $urandom;
        line_stride = $urandom;
        line_size   = SW'($urandom_range(1, 2047));
        frame_lines = LW'($urandom_range(1, 5));
    endtask

    task automatic write_done(input int unsigned b);
        wr_done = 1'b1;
        wr_buf  = BW'(b);
        tick();
        wr_done = 1'b0;
        if (b < BC) begin
            mdl_vld = 1'b1;
            mdl_buf = b;
        end
    endtask

    task automatic run_frame(input bit same_wr, input int unsigned wr_idx, input bit do_overrun);
        logic [AW-1:0] f_base, f_bstride, f_lstride, exp_addr;
        logic [SW-1:0] f_size;
        logic [LW-1:0] f_lines;
        int unsigned   sel;
        bit            go;
        f_base    = base_addr;
        f_bstride = buf_stride;
        f_lstride = line_stride;
        f_size    = line_size;
        f_lines   = frame_lines;
        frame_req = 1'b1;
        if (same_wr) begin
            wr_done = 1'b1;
            wr_buf  = BW'(wr_idx);
            if (wr_idx < BC) begin
                mdl_vld = 1'b1;
                mdl_buf = wr_idx;
            end
        end
        sel = mdl_buf;
        go  = mdl_vld && (f_lines != 0) && (f_size != 0);
        tick();
        frame_req = 1'b0;
        wr_done   = 1'b0;
        check("skip", frame_skip, !go);
        if (!go) begin
            tick();
            check("skip_no_stb", rd_stb, 1'b0);
            return;
        end
        cfg_random();
        tick();
        for (int unsigned k = 0; k < f_lines; k++) begin
            exp_addr = f_base + f_bstride * sel + f_lstride * k;
            check("stb", rd_stb, 1'b1);
            check("addr", rd_addr, exp_addr);
            check("size", rd_size, f_size);
            check("buf", rd_buf, sel);
            check("buf_vld", rd_buf_vld, 1'b1);
            tick();
            check("stb_pulse", rd_stb, 1'b0);
            if (do_overrun && k == 1) begin
                frame_req = 1'b1;
                tick();
                frame_req = 1'b0;
                check("overrun", frame_overrun, 1'b1);
            end
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("wait_no_stb", rd_stb, 1'b0);
            end
            line_done = 1'b1;
            tick();
            line_done = 1'b0;
            if (k == f_lines - 1) begin
                check("frame_done", frame_done, 1'b1);
                check("vld_clr", rd_buf_vld, 1'b0);
                check("no_timeout", timeout, 1'b0);
                tick();
                check("frame_done_pulse", frame_done, 1'b0);
            end else begin
                check("no_early_done", frame_done, 1'b0);
                check("issue_gap", rd_stb, 1'b0);
                tick();
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        frame_req = 1'b0;
        wr_done   = 1'b0;
        wr_buf    = '0;
        line_done = 1'b0;
        cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd1920, 12'd4);
        mdl_vld = 1'b0;
        mdl_buf = 0;
        repeat (3) tick();
        check("reset_outs", {rd_stb, rd_addr, rd_size, rd_buf, rd_buf_vld, frame_done,
                             frame_skip, frame_overrun, timeout}, '0);
        rst_n = 1'b1;
        tick();

        run_frame(1'b0, 0, 1'b0);

        write_done(1);
        cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd1920, 12'd4);
        run_frame(1'b0, 0, 1'b0);
        cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd1920, 12'd4);
        run_frame(1'b0, 0, 1'b0);

        write_done(3);
        cfg_set(32'hFFFF_F000, 32'h8000_0000, 32'h0000_0800, 11'd64, 12'd3);
        run_frame(1'b0, 0, 1'b0);

        write_done(0);
        cfg_set(32'h2000_0000, 32'h0040_0000, 32'h0000_1000, 11'd2047, 12'd2);
        run_frame(1'b1, 2, 1'b0);

        cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd1920, 12'd4);
        run_frame(1'b0, 0, 1'b1);

        cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd1920, 12'd0);
        run_frame(1'b0, 0, 1'b0);
        cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd0, 12'd4);
        run_frame(1'b0, 0, 1'b0);

        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        tick();
        check("idle_line_done_ignored", {rd_stb, frame_done}, '0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) write_done($urandom_range(0, 3));
            cfg_random();
            if ($urandom_range(0, 9) == 0) frame_lines = '0;
            if ($urandom_range(0, 9) == 0) line_size = '0;
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        write_done(2);
        cfg_random();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        tick();
        check("rst_pre_stb", rd_stb, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_frame_reset", {rd_stb, rd_addr, rd_size, rd_buf, rd_buf_vld, frame_done,
                                  frame_skip, frame_overrun, timeout}, '0);
        rst_n   = 1'b1;
        mdl_vld = 1'b0;
        mdl_buf = 0;
        tick();
        cfg_random();
        run_frame(1'b0, 0, 1'b0);

`ifdef FB_RD_SCHED_WATCHDOG_EN
        begin
            bit early;
            early = 1'b0;
            write_done(1);
            cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd1920, 12'd4);
            frame_req = 1'b1;
            tick();
            frame_req = 1'b0;
            tick();
            check("wd_stb", rd_stb, 1'b1);
            for (int unsigned c = 1; c < TO; c++) begin
                tick();
                if (timeout || frame_done) early = 1'b1;
            end
            check("wd_not_early", early, 1'b0);
            tick();
            check("wd_timeout", timeout, 1'b1);
            check("wd_vld_clr", rd_buf_vld, 1'b0);
            check("wd_no_done", frame_done, 1'b0);
            tick();
            check("wd_pulse", timeout, 1'b0);
            cfg_set(32'h1000_0000, 32'h0010_0000, 32'h0000_0800, 11'd1920, 12'd2);
            run_frame(1'b0, 0, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
